// File: rtl/header_stripper_if.sv
// header_stripper_if: AXI-Stream style beat bundle shared by the input, payload and metadata streams.
interface header_stripper_if #(parameter int DW = 128);
  logic [DW-1:0] tdata;
  logic tvalid;
  logic tready;
  logic tlast;
  modport master (output tdata, tvalid, tlast, input tready);
  modport slave (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/header_stripper.sv
// header_stripper: splits framed stream into payload and metadata, checks trailer sequence and framing.
module header_stripper #(
  parameter int DW = 128,
  parameter int META_DATA_LENGTH = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic [31:0] FRAME_SIZE,
  input  logic [31:0] PACKET_SIZE,
  header_stripper_if.slave  axis_in,
  header_stripper_if.master axis_out,
  header_stripper_if.master axis_out_meta,
  output logic [DW-1:0] frame_count,
  output logic frame_count_valid,
  output logic err_early_last,
  output logic err_missing_last,
  output logic err_seq,
  output logic [31:0] frames_ok
);
  typedef enum logic [1:0] {DATA, META, TRAILER, RESYNC} state_t;
  localparam logic [7:0] ML = 8'(META_DATA_LENGTH);
  state_t state, state_n;
  logic [31:0] dcnt, dcnt_n, d_last;
  logic [7:0] mcnt, mcnt_n;
  logic [DW-1:0] exp_q;
  logic armed, sel_d, sel_m, rdy, acc, early, trl, seq_bad;
  assign d_last = (PACKET_SIZE == 32'd0) ? 32'd0 : FRAME_SIZE / PACKET_SIZE;
  assign sel_d = resetn && state == DATA;
  assign sel_m = resetn && state == META;
  // Trailer and resync beats are always consumed; reset holds the input stalled.
  assign rdy = !resetn ? 1'b0 : sel_d ? axis_out.tready : sel_m ? axis_out_meta.tready : 1'b1;
  assign acc = axis_in.tvalid && rdy;
  assign axis_in.tready = rdy;
  assign axis_out.tdata = sel_d ? axis_in.tdata : '0;
  assign axis_out.tvalid = sel_d && axis_in.tvalid;
  assign axis_out.tlast = sel_d && axis_in.tvalid && (axis_in.tlast || dcnt == d_last);
  assign axis_out_meta.tdata = sel_m ? axis_in.tdata : '0;
  assign axis_out_meta.tvalid = sel_m && axis_in.tvalid;
  assign axis_out_meta.tlast = 1'b0;
  assign trl = acc && state == TRAILER;
  assign seq_bad = trl && armed && axis_in.tdata != exp_q + DW'(1);
  always_comb begin
    state_n = state;
    dcnt_n = dcnt;
    mcnt_n = mcnt;
    early = 1'b0;
    case (state)
      DATA: if (acc) begin
        early = axis_in.tlast;
        dcnt_n = (axis_in.tlast || dcnt == d_last) ? 32'd0 : dcnt + 32'd1;
        state_n = axis_in.tlast ? DATA : dcnt == d_last ? META : DATA;
      end
      META: if (acc) begin
        early = axis_in.tlast;
        dcnt_n = 32'd0;
        mcnt_n = (axis_in.tlast || mcnt == ML) ? 8'd0 : mcnt + 8'd1;
        state_n = axis_in.tlast ? DATA : mcnt == ML ? TRAILER : META;
      end
      TRAILER: if (acc) state_n = axis_in.tlast ? DATA : RESYNC;
      RESYNC: if (acc && axis_in.tlast) state_n = DATA;
      default: state_n = DATA;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= DATA;
      dcnt <= '0;
      mcnt <= '0;
      exp_q <= '0;
      armed <= 1'b0;
      frame_count <= '0;
      frame_count_valid <= 1'b0;
      err_early_last <= 1'b0;
      err_missing_last <= 1'b0;
      err_seq <= 1'b0;
      frames_ok <= '0;
    end else begin
      state <= state_n;
      dcnt <= dcnt_n;
      mcnt <= mcnt_n;
      frame_count_valid <= trl;
      err_early_last <= early;
      err_missing_last <= trl && !axis_in.tlast;
      err_seq <= seq_bad;
      if (trl) begin
        frame_count <= axis_in.tdata;
        exp_q <= axis_in.tdata;
        armed <= 1'b1;
      end
      if (trl && axis_in.tlast && !seq_bad) frames_ok <= frames_ok + 32'd1;
    end
  end
endmodule

// File: tb/tb_header_stripper.sv
// tb_header_stripper: directed vector table plus hand sequences for stall and mid-frame reset.
module tb_header_stripper;
  typedef struct {
    logic v, l;
    logic [31:0] d;
    logic ordy, mrdy, irdy, ov, ol, mv;
    logic [3:0] p;
  } vec_t;
  logic clk = 1'b0, resetn = 1'b0;
  logic [31:0] frame_size = 32'd4, packet_size = 32'd1, frame_count, frames_ok;
  logic fcv, ee, em, es;
  int checks = 0, errors = 0;
  vec_t tbl[$];
  header_stripper_if #(.DW(32)) in_if();
  header_stripper_if #(.DW(32)) out_if();
  header_stripper_if #(.DW(32)) meta_if();
  header_stripper #(.DW(32), .META_DATA_LENGTH(1)) dut (
    .clk(clk), .resetn(resetn), .FRAME_SIZE(frame_size), .PACKET_SIZE(packet_size),
    .axis_in(in_if), .axis_out(out_if), .axis_out_meta(meta_if),
    .frame_count(frame_count), .frame_count_valid(fcv), .err_early_last(ee),
    .err_missing_last(em), .err_seq(es), .frames_ok(frames_ok)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int id, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s row %0d act=%0h exp=%0h", n, id, a, e);
    end
  endtask
  function automatic vec_t mk(input logic v, l, input logic [31:0] d, input logic ordy, mrdy, irdy, ov, ol, mv, input logic [3:0] p);
    vec_t r;
    r.v = v; r.l = l; r.d = d; r.ordy = ordy; r.mrdy = mrdy;
    r.irdy = irdy; r.ov = ov; r.ol = ol; r.mv = mv; r.p = p;
    return r;
  endfunction
  task automatic step(input vec_t r, input int id);
    @(negedge clk);
    in_if.tvalid = r.v; in_if.tlast = r.l; in_if.tdata = r.d;
    out_if.tready = r.ordy; meta_if.tready = r.mrdy;
    #1;
    chk("in_tready", id, 32'(in_if.tready), 32'(r.irdy));
    chk("out_tvalid", id, 32'(out_if.tvalid), 32'(r.ov));
    chk("out_tlast", id, 32'(out_if.tlast), 32'(r.ol));
    chk("out_tdata", id, out_if.tdata, r.ov ? r.d : 32'd0);
    chk("meta_tvalid", id, 32'(meta_if.tvalid), 32'(r.mv));
    chk("meta_tdata", id, meta_if.tdata, r.mv ? r.d : 32'd0);
    chk("pulses_fcv_ee_em_es", id, 32'({fcv, ee, em, es}), 32'(r.p));
  endtask
  task automatic idle(input logic [3:0] p);
    tbl.push_back(mk(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, p));
  endtask
  // Frame of 5 payload beats, 2 meta beats and a trailer, for FRAME_SIZE=4, PACKET_SIZE=1.
  task automatic frame(input logic [31:0] base, input logic [31:0] trailer, input logic tl);
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1'b1, 1'b0, base + i, 1'b1, 1'b1, 1'b1, 1'b1, i == 4, 1'b0, 4'b0));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(1'b1, 1'b0, base + 8 + i, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0));
    tbl.push_back(mk(1'b1, tl, trailer, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0));
  endtask
  initial begin
    in_if.tvalid = 1'b1; in_if.tlast = 1'b1; in_if.tdata = 32'hABCD;
    out_if.tready = 1'b1; meta_if.tready = 1'b1;
    #12;
    chk("rst_in_tready", 0, 32'(in_if.tready), 32'd0);
    chk("rst_out_tvalid", 0, 32'(out_if.tvalid), 32'd0);
    chk("rst_out_tdata", 0, out_if.tdata, 32'd0);
    chk("rst_out_tlast", 0, 32'(out_if.tlast), 32'd0);
    chk("rst_regs", 0, frame_count | frames_ok | 32'({fcv, ee, em, es}), 32'd0);
    in_if.tvalid = 1'b0; in_if.tlast = 1'b0;
    @(negedge clk) resetn = 1'b1;
    frame(32'h100, 32'd7, 1'b1); idle(4'b1000);
    frame(32'h200, 32'd9, 1'b1); idle(4'b1001);
    tbl.push_back(mk(1'b1, 1'b0, 32'h300, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0));
    tbl.push_back(mk(1'b1, 1'b0, 32'h301, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0));
    tbl.push_back(mk(1'b1, 1'b1, 32'h302, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0));
    idle(4'b0100);
    frame(32'h400, 32'd10, 1'b1); idle(4'b1000);
    frame(32'h500, 32'd11, 1'b0); idle(4'b1010);
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b1, i == 2, 32'hDEAD0 + i, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0));
    frame(32'h600, 32'd12, 1'b1); idle(4'b1000);
    foreach (tbl[i]) step(tbl[i], i);
    chk("frames_ok_table", 1000, frames_ok, 32'd3);
    chk("frame_count_table", 1000, frame_count, 32'd12);
    // Payload stall: beat 1 held for 10 cycles must not advance the beat counter.
    step(mk(1'b1, 1'b0, 32'h700, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0), 2000);
    for (int i = 0; i < 10; i++) step(mk(1'b1, 1'b0, 32'h701, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0), 2001 + i);
    for (int i = 1; i < 5; i++) step(mk(1'b1, 1'b0, 32'h700 + i, 1'b1, 1'b1, 1'b1, 1'b1, i == 4, 1'b0, 4'b0), 2010 + i);
    for (int i = 0; i < 2; i++) step(mk(1'b1, 1'b0, 32'h708 + i, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0), 2020 + i);
    step(mk(1'b1, 1'b1, 32'd13, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0), 2030);
    step(mk(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000), 2031);
    chk("frames_ok_stall", 2032, frames_ok, 32'd4);
    chk("frame_count_stall", 2032, frame_count, 32'd13);
    // Reset in the middle of the metadata phase, then a one-beat-payload frame.
    for (int i = 0; i < 5; i++) step(mk(1'b1, 1'b0, 32'h800 + i, 1'b1, 1'b1, 1'b1, 1'b1, i == 4, 1'b0, 4'b0), 3000 + i);
    step(mk(1'b1, 1'b0, 32'h808, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0), 3005);
    @(negedge clk);
    in_if.tdata = 32'h809;
    resetn = 1'b0;
    #1;
    chk("mid_rst_in_tready", 3006, 32'(in_if.tready), 32'd0);
    chk("mid_rst_meta_tvalid", 3006, 32'(meta_if.tvalid), 32'd0);
    chk("mid_rst_meta_tdata", 3006, meta_if.tdata, 32'd0);
    chk("mid_rst_frames_ok", 3006, frames_ok, 32'd0);
    chk("mid_rst_frame_count", 3006, frame_count, 32'd0);
    in_if.tvalid = 1'b0;
    packet_size = 32'd0;
    @(negedge clk) resetn = 1'b1;
    step(mk(1'b1, 1'b0, 32'h900, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0), 3010);
    for (int i = 0; i < 2; i++) step(mk(1'b1, 1'b0, 32'h908 + i, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0), 3011 + i);
    step(mk(1'b1, 1'b1, 32'd50, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0), 3013);
    step(mk(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000), 3014);
    chk("frames_ok_after_rst", 3015, frames_ok, 32'd1);
    chk("frame_count_after_rst", 3015, frame_count, 32'd50);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/header_stripper.md
HEADER_STRIPPER -- requirements
Module: header_stripper

Interface
REQ-001 Parameter DW, default 128, width of every data bus.
REQ-002 Parameter META_DATA_LENGTH, default 1; each frame carries META_DATA_LENGTH+1 metadata beats; legal range 0..255.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 resetn  in  1  reset, asynchronous assert, active-low.
REQ-005 FRAME_SIZE  in  32  static configuration, stable while resetn=1.
REQ-006 PACKET_SIZE  in  32  static configuration, stable while resetn=1.
REQ-007 axis_in_tdata/tvalid/tlast  in  DW/1/1  framed stream from the header adder; axis_in_tready  out  1.
REQ-008 axis_out_tdata/tvalid/tlast  out  DW/1/1  payload stream; axis_out_tready  in  1.
REQ-009 axis_out_meta_tdata/tvalid  out  DW/1  metadata stream; axis_out_meta_tready  in  1.
REQ-010 frame_count  out  DW  last received trailer value; frame_count_valid  out  1  one-cycle pulse.
REQ-011 err_early_last, err_missing_last, err_seq  out  1 each  one-cycle error pulses.
REQ-012 frames_ok  out  32  count of frames completed without error.

Function
REQ-013 Frame format: D = FRAME_SIZE/PACKET_SIZE + 1 payload beats, then META_DATA_LENGTH+1 metadata beats, then 1 trailer beat with tlast=1.
REQ-014 PACKET_SIZE=0 yields D=1; the division is unsigned integer, truncating.
REQ-015 FSM states: DATA, META, TRAILER, RESYNC; reset state DATA.
REQ-016 Beat accepted = axis_in_tvalid & axis_in_tready on a rising edge.
REQ-017 In DATA, the payload path is a combinational pass-through:
- axis_out_tdata = axis_in_tdata
- axis_out_tvalid = axis_in_tvalid
- axis_in_tready = axis_out_tready
- axis_out_tlast = 1 only on payload beat index D-1.
REQ-018 In META, the meta path is a pass-through: axis_out_meta_* mirror the input; axis_in_tready = axis_out_meta_tready.
REQ-019 In TRAILER and RESYNC, axis_in_tready = 1 and both output valids = 0.
REQ-020 An unselected output has valid=0 and tdata=0.
REQ-021 Data beat counter (32-bit) advances per accepted beat in DATA; at index D-1 it clears and the FSM goes to META.
REQ-022 Meta counter (8-bit) advances per accepted beat in META; at index META_DATA_LENGTH it clears and the FSM goes to TRAILER.
REQ-023 Trailer accepted: frame_count registers axis_in_tdata, and frame_count_valid pulses on the next cycle.
REQ-024 Sequence check:
- err_seq pulses if the trailer value differs from expected (previous trailer + 1, modulo 2^DW).
- The first trailer after reset is never flagged.
- Expected is then reloaded from the received value.
REQ-025 Trailer with tlast=1 and no error: the FSM goes to DATA and frames_ok increments (wraps at 2^32).
REQ-026 Trailer with tlast=0: err_missing_last pulses, frame_count still updates, and the FSM goes to RESYNC.
REQ-027 RESYNC discards beats until an accepted beat has tlast=1, then goes to DATA.
REQ-028 Accepted beat with tlast=1 in DATA or META:
- err_early_last pulses.
- The beat is forwarded with axis_out_tlast=1.
- Counters clear and the FSM goes to DATA.
REQ-029 Error pulses and frame_count_valid are registered, one cycle wide, and occur one cycle after the causing beat.
REQ-030 Pass-through latency is 0 cycles; stalls (valid=1, ready=0) hold all state and counters.

Reset
REQ-031 While resetn=0, outputs are forced:
- axis_in_tready = 0
- all output valids = 0
- all tdata = 0, all tlast = 0
- frame_count = 0, frames_ok = 0, all pulses = 0.
REQ-032 Reset asserted mid-frame aborts the frame; after release the block expects payload beat 0 in DATA and re-arms the first-trailer exemption.

Verification
REQ-033 FRAME_SIZE=4, PACKET_SIZE=1, META_DATA_LENGTH=1, stream 5 data, 2 meta, trailer 7 with tlast -> expected response:
- 5 payload beats out, tlast on the 5th
- 2 meta beats out
- frame_count=7, frame_count_valid pulses once
- frames_ok=1.
REQ-034 Two frames with trailers 7 then 9 -> err_seq pulses once on the second frame; frames_ok=1.
REQ-035 tlast on data beat 2 of 5 -> expected response:
- err_early_last pulses
- beat forwarded with tlast=1
- next beat treated as data beat 0.
REQ-036 Trailer with tlast=0, then 3 junk beats (last with tlast=1), then a valid frame -> expected response:
- err_missing_last pulses
- junk is never forwarded
- the valid frame is parsed correctly.
REQ-037 axis_out_tready=0 for 10 cycles mid-payload -> axis_in_tready=0 for those cycles; no beat lost or duplicated; counter unchanged.
REQ-038 PACKET_SIZE=0 -> 1 data beat per frame; resetn pulsed low mid-meta -> all outputs 0 immediately and the next frame parses cleanly.
